// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial memory arbiter for instruction-fetch and load/store requests
//
// Purpose: serialises 32-bit instruction fetches and 1/2/4-byte loads/stores onto a
// byte-wide memory bus with one-cycle read latency. Requests are arbitrated in IDLE,
// latched on grant, then moved one byte per cycle, little-endian.
//
// Configuration: define MEM_ARBITER_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise load/store has fixed priority over instruction fetch.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   rdy                global enable; 0 freezes all state and idles the bus
//   if_req, if_addr    instruction-fetch request (always 4 bytes)
//   if_done, if_data   one-cycle completion pulse, fetched word (held until next fetch)
//   ls_req, ls_we, ls_size, ls_addr, ls_wdata   load/store request
//   ls_done, ls_rdata  one-cycle completion pulse, zero-extended load data
//   mem_a, mem_dout, mem_wr, mem_din            byte-serial memory bus
//   io_full            IO output buffer full; stalls writes into the IO region
module mem_arbiter #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    input  logic        io_full
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;        // bytes captured (reads) / written (writes)
    logic        iss_q, iss_d;        // address for byte cnt_q was issued last cycle
    logic        is_ls_q, is_ls_d;
    logic        we_q, we_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
`ifdef MEM_ARBITER_RR_EN
    logic        rr_q, rr_d;          // 1: load/store was served last, favour fetch
`endif

    logic        pick_ls;
    logic [2:0]  nxt;
    logic [31:0] cur;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        iss_d      = iss_q;
        is_ls_d    = is_ls_q;
        we_d       = we_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARBITER_RR_EN
        rr_d       = rr_q;
        pick_ls    = ls_req && (!if_req || !rr_q);
`else
        pick_ls    = ls_req;
`endif
        nxt        = iss_q ? (cnt_q + 3'd1) : cnt_q;
        cur        = addr_q + {29'd0, cnt_q};
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        mem_wr     = 1'b0;

        if (!rdy) begin
            // The RAM sees address 0 while frozen, so any in-flight read is re-issued.
            iss_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // No grant in the cycle a done is shown, so a requester can drop its request.
                    if (!if_done_q && !ls_done_q && (ls_req || if_req)) begin
                        state_d = BUSY;
                        cnt_d   = 3'd0;
                        iss_d   = 1'b0;
                        buf_d   = 32'd0;
`ifdef MEM_ARBITER_RR_EN
                        rr_d    = pick_ls;
`endif
                        if (pick_ls) begin
                            is_ls_d = 1'b1;
                            we_d    = ls_we;
                            addr_d  = ls_addr;
                            wdata_d = ls_wdata;
                            case (ls_size)
                                2'd0:    len_d = 3'd1;
                                2'd1:    len_d = 3'd2;
                                default: len_d = 3'd4;
                            endcase
                        end else begin
                            is_ls_d = 1'b0;
                            we_d    = 1'b0;
                            addr_d  = if_addr;
                            wdata_d = 32'd0;
                            len_d   = 3'd4;
                        end
                    end
                end
                BUSY: begin
                    if (we_q) begin
                        if (!(cur[RAM_ADDR_WIDTH -: 2] == 2'b11 && io_full)) begin
                            mem_wr   = 1'b1;
                            mem_a    = cur;
                            mem_dout = wdata_q[8*cnt_q[1:0] +: 8];
                            if (cnt_q == len_q - 3'd1) begin
                                state_d   = IDLE;
                                ls_done_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 3'd1;
                            end
                        end
                    end else begin
                        if (iss_q) begin
                            buf_d[8*cnt_q[1:0] +: 8] = mem_din;
                        end
                        cnt_d = nxt;
                        if (nxt < len_q) begin
                            mem_a = addr_q + {29'd0, nxt};
                            iss_d = 1'b1;
                        end else begin
                            iss_d = 1'b0;
                        end
                        if (nxt == len_q) begin
                            state_d = IDLE;
                            if (is_ls_q) begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = buf_d;
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = buf_d;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            iss_q      <= 1'b0;
            is_ls_q    <= 1'b0;
            we_q       <= 1'b0;
            len_q      <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
`ifdef MEM_ARBITER_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iss_q      <= iss_d;
            is_ls_q    <= is_ls_d;
            we_q       <= we_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARBITER_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rdy, io_full;
    logic        if_req, ls_req, ls_we;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_dout, mem_din;

    mem_arbiter #(.RAM_ADDR_WIDTH(17)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_full(io_full)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end

    logic [31:0] exp_if[$];
    logic [31:0] exp_ls[$];
    logic [39:0] exp_wr[$];
    int          wr_cycs[$];
    int          done_log[$];
    int          ifd_n = 0, lsd_n = 0, ifd_cyc = 0, lsd_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a done pulse.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_cycs.push_back(cyc);
            if (exp_wr.size() == 0) check("wr_unexpected", 64'(exp_wr.size()), 64'd1);
            else check("wr_bus", {24'd0, mem_a, mem_dout}, {24'd0, exp_wr.pop_front()});
        end
        if (if_done === 1'b1) begin
            ifd_n++; ifd_cyc = cyc; done_log.push_back(0);
            if (exp_if.size() == 0) check("if_unexpected", 64'(exp_if.size()), 64'd1);
            else check("if_data", {32'd0, if_data}, {32'd0, exp_if.pop_front()});
        end
        if (ls_done === 1'b1) begin
            lsd_n++; lsd_cyc = cyc; done_log.push_back(1);
            if (exp_ls.size() == 0) check("ls_unexpected", 64'(exp_ls.size()), 64'd1);
            else check("ls_rdata", {32'd0, ls_rdata}, {32'd0, exp_ls.pop_front()});
        end
    end

    task automatic wait_if(input int start_n, output int c);
        int k = 0;
        while (ifd_n == start_n && k < 60) begin @(negedge clk); #1; k++; end
        if (ifd_n == start_n) check("if_timeout", 64'(ifd_n), 64'(start_n + 1));
        c = ifd_cyc;
    endtask

    task automatic wait_ls(input int start_n, output int c);
        int k = 0;
        while (lsd_n == start_n && k < 60) begin @(negedge clk); #1; k++; end
        if (lsd_n == start_n) check("ls_timeout", 64'(lsd_n), 64'(start_n + 1));
        c = lsd_cyc;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic fetch_freeze(input int fstart, input bit chk_lat);
        int t0, n, c;
        t0 = cyc; n = ifd_n;
        if_addr = 32'h100; if_req = 1'b1;
        exp_if.push_back(32'h9305_0013);
        repeat (fstart + 1) @(posedge clk);
        #1; rdy = 1'b0;
        @(negedge clk); check("frz_bus0", {31'd0, mem_wr, mem_a}, 64'd0);
        check("frz_dout0", {56'd0, mem_dout}, 64'd0);
        next_cycle();
        @(negedge clk); check("frz_bus1", {31'd0, mem_wr, mem_a}, 64'd0);
        next_cycle(); rdy = 1'b1;
        wait_if(n, c);
        if (chk_lat) check("frz_latency", 64'(c - t0), 64'd8);
        next_cycle(); if_req = 1'b0;
    endtask

    initial begin
        int t0, n, n2, c, c2, wn, s;
        int exp_order[4];
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[16'h100] = 8'h13; ram[16'h101] = 8'h00; ram[16'h102] = 8'h05; ram[16'h103] = 8'h93;
        ram[16'h010] = 8'hC7;
        rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0;
        if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {61'd0, if_done, ls_done, mem_wr}, 64'd0);
        check("rst_bus", {24'd0, mem_a, mem_dout}, 64'd0);
        check("rst_data", {if_data, ls_rdata}, 64'd0);
        next_cycle(); rst_n = 1'b1;
        next_cycle();

        // Word fetch 0x100
        t0 = cyc; n = ifd_n;
        if_addr = 32'h100; if_req = 1'b1; exp_if.push_back(32'h9305_0013);
        wait_if(n, c);
        check("fetch_latency", 64'(c - t0), 64'd6);
        next_cycle(); if_req = 1'b0;

        // Half-word store at 0x201
        t0 = cyc; n = lsd_n; wn = wr_cycs.size();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h201; ls_wdata = 32'hABCD_1234;
        exp_wr.push_back({32'h201, 8'h34}); exp_wr.push_back({32'h202, 8'h12});
        exp_ls.push_back(32'd0);
        wait_ls(n, c);
        check("sh_latency", 64'(c - t0), 64'd3);
        check("sh_nwr", 64'(wr_cycs.size() - wn), 64'd2);
        if (wr_cycs.size() >= wn + 2) begin
            check("sh_wr0_cyc", 64'(wr_cycs[wn] - t0), 64'd1);
            check("sh_wr1_cyc", 64'(wr_cycs[wn+1] - t0), 64'd2);
        end
        next_cycle(); ls_req = 1'b0;

        // IO byte store stalled by io_full for 3 busy cycles
        t0 = cyc; n = lsd_n; wn = wr_cycs.size();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
        io_full = 1'b1;
        exp_wr.push_back({32'h3_0000, 8'h41}); exp_ls.push_back(32'd0);
        repeat (4) @(posedge clk);
        #1; io_full = 1'b0;
        wait_ls(n, c);
        check("io_latency", 64'(c - t0), 64'd5);
        check("io_nwr", 64'(wr_cycs.size() - wn), 64'd1);
        if (wr_cycs.size() > wn) check("io_wr_cyc", 64'(wr_cycs[wn] - t0), 64'd4);
        next_cycle(); ls_req = 1'b0;

        // Simultaneous fetch and byte load: load first, fetch granted the cycle after ls_done
        t0 = cyc; n = lsd_n; n2 = ifd_n;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h100;
        exp_ls.push_back(32'h0000_00C7); exp_if.push_back(32'h9305_0013);
        fork
            begin
                wait_ls(n, c);
                check("arb_ls_latency", 64'(c - t0), 64'd3);
                next_cycle(); ls_req = 1'b0;
            end
            begin
                wait_if(n2, c2);
                check("arb_if_latency", 64'(c2 - t0), 64'd10);
                next_cycle(); if_req = 1'b0;
            end
        join

        // Both requests held continuously for four completions
        s = done_log.size();
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h100;
`ifdef MEM_ARBITER_RR_EN
        exp_order = '{1, 0, 1, 0};
        exp_ls.push_back(32'hC7); exp_if.push_back(32'h9305_0013);
        exp_ls.push_back(32'hC7); exp_if.push_back(32'h9305_0013);
`else
        exp_order = '{1, 1, 1, 1};
        repeat (4) exp_ls.push_back(32'hC7);
`endif
        for (int k = 0; k < 80 && done_log.size() < s + 4; k++) begin
            @(negedge clk); #1;
        end
        next_cycle(); ls_req = 1'b0; if_req = 1'b0;
        check("held_ndone", 64'(done_log.size() - s), 64'd4);
        if (done_log.size() >= s + 4)
            for (int i = 0; i < 4; i++) check("held_order", 64'(done_log[s+i]), 64'(exp_order[i]));
        next_cycle();

        // rdy low for two cycles at the start of a fetch, then mid-fetch
        fetch_freeze(0, 1'b1);
        fetch_freeze(2, 1'b0);

        // Reset during byte 2 of a word store
        n = lsd_n; wn = wr_cycs.size();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'h1122_3344;
        exp_wr.push_back({32'h400, 8'h44}); exp_wr.push_back({32'h401, 8'h33});
        exp_wr.push_back({32'h402, 8'h22});
        next_cycle(); ls_req = 1'b0;
        next_cycle();
        next_cycle(); rst_n = 1'b0;
        next_cycle(); rst_n = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {61'd0, if_done, ls_done, mem_wr}, 64'd0);
        check("abort_bus", {24'd0, mem_a, mem_dout}, 64'd0);
        check("abort_data", {if_data, ls_rdata}, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 64'(lsd_n), 64'(n));
        check("abort_nwr", 64'(wr_cycs.size() - wn), 64'd3);

        // Arbiter is idle and usable after the aborted transfer
        t0 = cyc; n = ifd_n;
        if_addr = 32'h100; if_req = 1'b1; exp_if.push_back(32'h9305_0013);
        wait_if(n, c);
        check("post_rst_latency", 64'(c - t0), 64'd6);
        next_cycle(); if_req = 1'b0;
        repeat (3) next_cycle();

        check("sb_drain", 64'(exp_if.size() + exp_ls.size() + exp_wr.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
